// File: rtl/eth_frame_tx.sv
// eth_frame_tx - Ethernet frame transmitter, MAC-side dibit stream.
//
// Builds DA, SA (SRC_MAC), ethertype, payload, zero pad up to MIN_PAYLOAD
// and, optionally, the FCS. Each byte goes out first-byte-first as four
// dibits [7:6],[5:4],[3:2],[1:0] on axiod while axiov is high. After every
// frame IFG_CYCLES idle cycles follow before the block returns to IDLE.
//
// Optional feature macro: ETH_TX_FCS_EN
//   defined   : CRC-32 (reflected 0xEDB88320, init all-ones, complemented)
//               over DA..pad, appended as 4 bytes, ~crc[7:0] first.
//   undefined : no CRC logic, frame goes from payload/pad straight to IFG.
//
// Ports
//   clk       in   system clock
//   rst       in   asynchronous active-low reset
//   start     in   frame request, sampled only in IDLE
//   dst_mac   in   destination MAC, latched on accepted start
//   ethertype in   type/length, latched on accepted start
//   in_data   in   payload byte
//   in_valid  in   in_data valid
//   in_last   in   in_data is the final payload byte
//   in_ready  out  byte taken this cycle when in_valid & in_ready
//   busy      out  not in IDLE
//   axiov     out  dibit valid (registered)
//   axiod     out  dibit, 2'b00 while axiov=0 (registered)
//   done      out  1-cycle pulse in last IFG cycle of a good frame
//   err       out  1-cycle pulse on payload underrun
module eth_frame_tx #(
    parameter logic [47:0] SRC_MAC     = 48'hFE_ED_B0_BA_F1_DD,
    parameter int          MIN_PAYLOAD = 46,
    parameter int          IFG_CYCLES  = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [47:0] dst_mac,
    input  logic [15:0] ethertype,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic        busy,
    output logic        axiov,
    output logic [1:0]  axiod,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR     = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_PAD     = 3'd3;
`ifdef ETH_TX_FCS_EN
    localparam logic [2:0] S_FCS     = 3'd4;
`endif
    localparam logic [2:0] S_IFG     = 3'd5;

    localparam int               IFG_W    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_CYCLES - 1);
    localparam logic [10:0]      MIN_CNT  = 11'(MIN_PAYLOAD);

    function automatic logic [1:0] dsel(input logic [7:0] b, input logic [1:0] d);
        case (d)
            2'd0:    return b[7:6];
            2'd1:    return b[5:4];
            2'd2:    return b[3:2];
            default: return b[1:0];
        endcase
    endfunction

`ifdef ETH_TX_FCS_EN
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction
`endif

    logic [2:0]       state, state_n;
    logic [111:0]     hdr_sr, hdr_n;     // DA|SA|type, top byte is the one on the wire
    logic [7:0]       cur_byte, cur_n;   // payload / pad / FCS byte on the wire
    logic [1:0]       dib, dib_n;        // dibit index within the current byte
    logic [3:0]       idx, idx_n;        // header byte index, reused as FCS byte index
    logic [10:0]      bcnt, bcnt_n;      // payload+pad bytes, saturating
    logic             last_seen, last_n; // current payload byte carried in_last
    logic             bad, bad_n;        // underrun: suppress done
    logic [IFG_W-1:0] icnt, icnt_n;
    logic             v_n, err_n, done_n;
    logic [1:0]       axiod_n;
    logic [7:0]       byte_next;
    logic             byte_end;
`ifdef ETH_TX_FCS_EN
    logic [31:0]      crc, crc_n, crc_upd;
    logic [7:0]       byte_now;

    // crc doubles as the FCS shift register once the body is complete
    assign byte_now = (state == S_HDR) ? hdr_sr[111:104] : cur_byte;
    assign crc_upd  = crc_byte(crc, byte_now);
`endif

    assign byte_end = (dib == 2'd3);
    assign busy     = (state != S_IDLE);
    // Load points: last header dibit and last dibit of each non-final payload byte
    assign in_ready = byte_end &&
                      (((state == S_HDR) && (idx == 4'd13)) ||
                       ((state == S_PAYLOAD) && !last_seen));

    always_comb begin
        state_n = state;
        hdr_n   = hdr_sr;
        cur_n   = cur_byte;
        dib_n   = dib;
        idx_n   = idx;
        bcnt_n  = bcnt;
        last_n  = last_seen;
        bad_n   = bad;
        icnt_n  = icnt;
        v_n     = 1'b0;
        err_n   = 1'b0;
`ifdef ETH_TX_FCS_EN
        crc_n   = crc;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_HDR;
                    hdr_n   = {dst_mac, SRC_MAC, ethertype};
                    dib_n   = 2'd0;
                    idx_n   = 4'd0;
                    bcnt_n  = 11'd0;
                    last_n  = 1'b0;
                    bad_n   = 1'b0;
                    v_n     = 1'b1;
`ifdef ETH_TX_FCS_EN
                    crc_n   = '1;
`endif
                end
            end
            S_HDR: begin
                v_n   = 1'b1;
                dib_n = dib + 2'd1;
                if (byte_end) begin
`ifdef ETH_TX_FCS_EN
                    crc_n = crc_upd;
`endif
                    // last header byte falls through to the load override below
                    if (idx != 4'd13) begin
                        hdr_n = hdr_sr << 8;
                        idx_n = idx + 4'd1;
                    end
                end
            end
            S_PAYLOAD, S_PAD: begin
                v_n   = 1'b1;
                dib_n = dib + 2'd1;
                if (byte_end) begin
`ifdef ETH_TX_FCS_EN
                    crc_n = crc_upd;
`endif
                    // body ends after the final payload byte or final pad byte
                    if ((state == S_PAD) || last_seen) begin
                        if (bcnt < MIN_CNT) begin
                            state_n = S_PAD;
                            cur_n   = 8'h00;
                            bcnt_n  = bcnt + 11'd1;
                        end else begin
`ifdef ETH_TX_FCS_EN
                            state_n = S_FCS;
                            idx_n   = 4'd0;
                            cur_n   = ~crc_upd[7:0];
`else
                            state_n = S_IFG;
                            icnt_n  = '0;
                            v_n     = 1'b0;
`endif
                        end
                    end
                end
            end
`ifdef ETH_TX_FCS_EN
            S_FCS: begin
                v_n   = 1'b1;
                dib_n = dib + 2'd1;
                if (byte_end) begin
                    if (idx == 4'd3) begin
                        state_n = S_IFG;
                        icnt_n  = '0;
                        v_n     = 1'b0;
                    end else begin
                        crc_n = crc >> 8;
                        cur_n = ~crc[15:8];
                        idx_n = idx + 4'd1;
                    end
                end
            end
`endif
            S_IFG: begin
                if (icnt == IFG_LAST) state_n = S_IDLE;
                else                  icnt_n  = icnt + 1'b1;
            end
            default: state_n = S_IDLE;
        endcase

        if (in_ready) begin
            if (in_valid) begin
                state_n = S_PAYLOAD;
                cur_n   = in_data;
                last_n  = in_last;
                bcnt_n  = (bcnt == 11'h7FF) ? bcnt : bcnt + 11'd1;
                v_n     = 1'b1;
            end else begin
                state_n = S_IFG;
                icnt_n  = '0;
                v_n     = 1'b0;
                err_n   = 1'b1;
                bad_n   = 1'b1;
            end
        end

        done_n    = (state_n == S_IFG) && (icnt_n == IFG_LAST) && !bad_n;
        byte_next = (state_n == S_HDR) ? hdr_n[111:104] : cur_n;
        axiod_n   = v_n ? dsel(byte_next, dib_n) : 2'b00;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            hdr_sr    <= '0;
            cur_byte  <= '0;
            dib       <= '0;
            idx       <= '0;
            bcnt      <= '0;
            last_seen <= 1'b0;
            bad       <= 1'b0;
            icnt      <= '0;
            axiov     <= 1'b0;
            axiod     <= 2'b00;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef ETH_TX_FCS_EN
            crc       <= '0;
`endif
        end else begin
            state     <= state_n;
            hdr_sr    <= hdr_n;
            cur_byte  <= cur_n;
            dib       <= dib_n;
            idx       <= idx_n;
            bcnt      <= bcnt_n;
            last_seen <= last_n;
            bad       <= bad_n;
            icnt      <= icnt_n;
            axiov     <= v_n;
            axiod     <= axiod_n;
            done      <= done_n;
            err       <= err_n;
`ifdef ETH_TX_FCS_EN
            crc       <= crc_n;
`endif
        end
    end

endmodule
